// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: one outstanding imem request feeding a DEPTH-entry {pc, instr} FIFO.
// Optional misaligned-fetch fault entries are enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_buffer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic               pc_advance,
  input  logic               flush,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic               fetch_fault
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    DISCARD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   req_pc_q;
  logic [ADDR_W-1:0]   pc_mem    [DEPTH];
  logic [INSTR_W-1:0]  instr_mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;

  logic                has_room;
  logic                misaligned;
  logic                req_valid;
  logic                accept;
  logic                push;
  logic                pop;
  logic                fault_push;
  logic [ADDR_W-1:0]   push_pc;
  logic [INSTR_W-1:0]  push_instr;

  // While in IDLE no request is outstanding, so the FIFO count alone is the occupancy.
  assign has_room = count_q < CNT_W'(DEPTH);
  assign pop      = (count_q != '0) && id_ready;

`ifdef FETCH_MISALIGN_CHK_EN
  assign misaligned = (pc_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Next-state, request handshake and push selection.
  always_comb begin
    state_d    = state_q;
    req_valid  = 1'b0;
    accept     = 1'b0;
    push       = 1'b0;
    fault_push = 1'b0;
    push_pc    = req_pc_q;
    push_instr = imem_rsp_data;
    case (state_q)
      IDLE: begin
        if (!flush && has_room) begin
          if (misaligned) begin
            push       = 1'b1;
            fault_push = 1'b1;
            push_pc    = pc_in;
            push_instr = NOP_INSTR;
          end else begin
            req_valid = 1'b1;
            if (imem_req_ready) begin
              accept  = 1'b1;
              state_d = WAIT_RSP;
            end
          end
        end
      end
      WAIT_RSP: begin
        if (imem_rsp_valid) begin
          push    = !flush;
          state_d = IDLE;
        end else if (flush) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      req_pc_q <= '0;
    else if (accept) req_pc_q <= pc_in;
  end

  // FIFO storage and pointers; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr_q]    <= push_pc;
        instr_mem[wr_ptr_q] <= push_instr;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (!push && pop) count_q <= count_q - CNT_W'(1);
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault_mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) fault_mem[i] <= 1'b0;
    end else if (!flush && push) begin
      fault_mem[wr_ptr_q] <= fault_push;
    end
  end

  assign fetch_fault = fault_mem[rd_ptr_q];
`else
  assign fetch_fault = 1'b0;
`endif

  // Request-side outputs are combinational; forced low while reset is held.
  assign imem_req_valid = reset && req_valid;
  assign imem_req_addr  = reset ? pc_in : '0;
  assign pc_advance     = reset && (accept || fault_push);

  assign id_valid = (count_q != '0);
  assign id_pc    = pc_mem[rd_ptr_q];
  assign id_instr = instr_mem[rd_ptr_q];

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus randomized traffic against a transaction-level
// model (queue of expected entries, one-outstanding-request tracker, latency-driven memory).
module tb_fetch_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [63:0] pc_in;
  logic        pc_advance;
  logic        flush;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic        fetch_fault;

  fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(64), .INSTR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (pc_in),
    .pc_advance     (pc_advance),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  int          total = 0;
  int          bad   = 0;
  ent_t        q[$];
  bit          busy;
  bit          dropping;
  logic [63:0] req_pc;
  int          mem_cnt;
  logic [31:0] mem_data;
  int          force_lat;

  function automatic logic [31:0] imem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic bit mis_chk();
`ifdef FETCH_MISALIGN_CHK_EN
    return pc_in[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit can_issue();
    return reset && !flush && !busy && (q.size() < DEPTH);
  endfunction

  function automatic bit exp_req_valid();
    return can_issue() && !mis_chk();
  endfunction

  function automatic bit exp_fault_push();
    return can_issue() && mis_chk();
  endfunction

  // Drive inputs just after a rising edge; outputs are read 2 time units later.
  task automatic drive(input bit fl, input bit idr, input bit rqr, input logic [63:0] pc);
    flush          = fl;
    id_ready       = idr;
    imem_req_ready = rqr;
    pc_in          = pc;
    imem_rsp_valid = reset && (mem_cnt == 1);
    imem_rsp_data  = (mem_cnt == 1) ? mem_data : $urandom;
    #2;
  endtask

  // Advance one clock and update the reference model from this cycle's inputs.
  task automatic tick();
    bit          acc, fp, pop, rsp;
    logic [63:0] pc;
    ent_t        e;
    acc = exp_req_valid() && imem_req_ready;
    fp  = exp_fault_push();
    pop = (q.size() != 0) && id_ready;
    rsp = imem_rsp_valid;
    pc  = pc_in;
    if (flush) begin
      q.delete();
      if (busy) begin
        if (rsp) begin busy = 0; dropping = 0; end
        else dropping = 1;
      end
    end else begin
      if (pop) q.delete(0);
      if (busy && rsp) begin
        if (!dropping) begin
          e.pc = req_pc; e.instr = imem_word(req_pc); e.fault = 1'b0;
          q.push_back(e);
        end
        busy = 0; dropping = 0;
      end
      if (fp) begin
        e.pc = pc; e.instr = 32'h0000_0013; e.fault = 1'b1;
        q.push_back(e);
      end
      if (acc) begin busy = 1; req_pc = pc; end
    end
    @(posedge clk);
    #1;
    if (mem_cnt != 0) mem_cnt--;
    if (acc) begin
      mem_cnt  = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
      mem_data = imem_word(pc);
    end
  endtask

  task automatic clear_model();
    q.delete();
    busy = 0; dropping = 0; mem_cnt = 0; req_pc = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    flush = 1'b0; id_ready = 1'b0; imem_req_ready = 1'b0; pc_in = '0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    clear_model();
    force_lat = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [226:0] outs;
    apply_reset();
    force_lat = 1;
    drive(0, 0, 1, 64'h40); tick();
    drive(0, 0, 0, 64'h40); tick();
    force_lat = 20;
    drive(0, 0, 1, 64'h44); tick();
    drive(0, 0, 0, 64'h48);
    total++;
    if (id_valid !== 1'b1 || id_pc !== 64'h40) begin
      bad++; $display("FAIL reset_prefill: id_valid=%b id_pc=%h want 1 40", id_valid, id_pc);
    end
    reset = 1'b0;
    clear_model();
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 1, 64'h48);
      outs = {imem_req_valid, imem_req_addr, pc_advance, id_valid, id_pc, id_instr, fetch_fault};
      total++;
      if (outs !== '0) begin
        bad++; $display("FAIL reset_outputs: cycle %0d got %h want 0", c, outs);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    drive(0, 0, 1, 64'h0);
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0 || pc_advance !== 1'b1 || id_valid !== 1'b0) begin
      bad++; $display("FAIL reset_release: rv=%b addr=%h adv=%b idv=%b want 1 0 1 0",
                      imem_req_valid, imem_req_addr, pc_advance, id_valid);
    end
    tick();
  endtask

  task automatic test_stream();
    int nacc = 0;
    bit ev, ea;
    logic [63:0] epc;
    apply_reset();
    force_lat = 1;
    for (int c = 0; c < 8; c++) begin
      drive(0, 1, nacc < 3, 64'(4 * nacc));
      ev = (c == 2 || c == 4 || c == 6);
      ea = (c == 0 || c == 2 || c == 4);
      total++;
      if (id_valid !== ev) begin
        bad++; $display("FAIL stream_valid: cycle %0d got %b want %b", c, id_valid, ev);
      end
      if (ev) begin
        epc = 64'(4 * (c / 2 - 1));
        total++;
        if (id_pc !== epc || id_instr !== imem_word(epc)) begin
          bad++; $display("FAIL stream_data: cycle %0d got %h/%h want %h/%h", c, id_pc, id_instr, epc, imem_word(epc));
        end
      end
      total++;
      if (pc_advance !== ea) begin
        bad++; $display("FAIL stream_adv: cycle %0d got %b want %b", c, pc_advance, ea);
      end
      if (exp_req_valid() && imem_req_ready) nacc++;
      tick();
    end
  endtask

  task automatic test_full();
    int nacc = 0;
    int adv  = 0;
    int k    = 0;
    apply_reset();
    force_lat = 1;
    for (int c = 0; c < 12; c++) begin
      drive(0, 0, 1, 64'(4 * nacc));
      if (pc_advance === 1'b1) adv++;
      if (exp_req_valid() && imem_req_ready) nacc++;
      tick();
    end
    total++;
    if (adv != 4) begin bad++; $display("FAIL full_accepts: got %0d want 4", adv); end
    drive(0, 0, 1, 64'h10);
    total++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b1) begin
      bad++; $display("FAIL full_stall: rv=%b idv=%b want 0 1", imem_req_valid, id_valid);
    end
    tick();
    drive(0, 1, 1, 64'h10);
    total++;
    if (id_pc !== 64'h0 || imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL full_pop: id_pc=%h rv=%b want 0 0", id_pc, imem_req_valid);
    end
    tick();
    drive(0, 0, 1, 64'h10);
    total++;
    if (imem_req_valid !== 1'b1 || pc_advance !== 1'b1) begin
      bad++; $display("FAIL full_refill: rv=%b adv=%b want 1 1", imem_req_valid, pc_advance);
    end
    tick();
    for (int c = 0; c < 10; c++) begin
      drive(0, 1, 0, 64'h0);
      if (id_valid === 1'b1) begin
        total++;
        if (id_pc !== 64'(4 * (k + 1))) begin
          bad++; $display("FAIL full_drain: entry %0d got %h want %h", k, id_pc, 64'(4 * (k + 1)));
        end
        k++;
      end
      tick();
    end
    total++;
    if (k != 4) begin bad++; $display("FAIL full_drain_count: got %0d want 4", k); end
  endtask

  task automatic test_flush_inflight();
    apply_reset();
    force_lat = 4;
    drive(0, 0, 1, 64'h10);
    total++;
    if (pc_advance !== 1'b1 || imem_req_addr !== 64'h10) begin
      bad++; $display("FAIL fl_accept: adv=%b addr=%h want 1 10", pc_advance, imem_req_addr);
    end
    tick();
    drive(1, 0, 1, 64'h10);
    total++;
    if (imem_req_valid !== 1'b0 || pc_advance !== 1'b0) begin
      bad++; $display("FAIL fl_flush: rv=%b adv=%b want 0 0", imem_req_valid, pc_advance);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 1, 64'h200);
      total++;
      if (imem_req_valid !== 1'b0) begin
        bad++; $display("FAIL fl_discard: cycle %0d rv=%b want 0", c, imem_req_valid);
      end
      tick();
    end
    drive(0, 0, 1, 64'h200);
    total++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h200) begin
      bad++; $display("FAIL fl_resume: idv=%b rv=%b addr=%h want 0 1 200", id_valid, imem_req_valid, imem_req_addr);
    end
    tick();
  endtask

  task automatic test_flush_rsp();
    int nacc = 0;
    apply_reset();
    force_lat = 1;
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 1, 64'h20 + 64'(4 * nacc));
      if (exp_req_valid() && imem_req_ready) nacc++;
      tick();
    end
    drive(1, 1, 0, 64'h40);
    total++;
    if (id_valid !== 1'b1 || imem_rsp_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      bad++; $display("FAIL fr_setup: idv=%b rsp=%b rv=%b want 1 1 0", id_valid, imem_rsp_valid, imem_req_valid);
    end
    tick();
    drive(0, 0, 1, 64'h40);
    total++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || pc_advance !== 1'b1) begin
      bad++; $display("FAIL fr_after: idv=%b rv=%b adv=%b want 0 1 1", id_valid, imem_req_valid, pc_advance);
    end
    tick();
  endtask

  task automatic test_misalign();
    apply_reset();
    force_lat = 1;
`ifdef FETCH_MISALIGN_CHK_EN
    drive(0, 0, 1, 64'h102);
    total++;
    if (imem_req_valid !== 1'b0 || pc_advance !== 1'b1) begin
      bad++; $display("FAIL mis_push: rv=%b adv=%b want 0 1", imem_req_valid, pc_advance);
    end
    tick();
    drive(0, 0, 0, 64'h104);
    total++;
    if (id_valid !== 1'b1 || id_pc !== 64'h102 || fetch_fault !== 1'b1 || id_instr !== 32'h13) begin
      bad++; $display("FAIL mis_entry: v=%b pc=%h f=%b i=%h want 1 102 1 13", id_valid, id_pc, fetch_fault, id_instr);
    end
    tick();
`else
    drive(0, 0, 1, 64'h102);
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h102 || pc_advance !== 1'b1) begin
      bad++; $display("FAIL mis_req: rv=%b addr=%h adv=%b want 1 102 1", imem_req_valid, imem_req_addr, pc_advance);
    end
    tick();
    drive(0, 0, 0, 64'h106); tick();
    drive(0, 0, 0, 64'h106);
    total++;
    if (id_valid !== 1'b1 || id_pc !== 64'h102 || fetch_fault !== 1'b0 || id_instr !== imem_word(64'h102)) begin
      bad++; $display("FAIL mis_entry: v=%b pc=%h f=%b i=%h want 1 102 0 %h", id_valid, id_pc, fetch_fault, id_instr, imem_word(64'h102));
    end
    tick();
`endif
  endtask

  task automatic test_random();
    bit          fl, idr, rqr, ev, ea, eq;
    logic [63:0] pc;
    apply_reset();
    force_lat = 0;
    for (int c = 0; c < 3000; c++) begin
      fl  = ($urandom_range(0, 15) == 0);
      idr = 1'($urandom_range(0, 1));
      rqr = ($urandom_range(0, 9) < 7);
      pc  = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
      drive(fl, idr, rqr, pc);
      ev = exp_req_valid();
      ea = (ev && rqr) || exp_fault_push();
      eq = (q.size() != 0);
      total++;
      if (imem_req_valid !== ev) begin
        bad++; $display("FAIL rnd_req_valid: cycle %0d got %b want %b", c, imem_req_valid, ev);
      end
      total++;
      if (pc_advance !== ea) begin
        bad++; $display("FAIL rnd_adv: cycle %0d got %b want %b", c, pc_advance, ea);
      end
      if (ev) begin
        total++;
        if (imem_req_addr !== pc) begin
          bad++; $display("FAIL rnd_addr: cycle %0d got %h want %h", c, imem_req_addr, pc);
        end
      end
      total++;
      if (id_valid !== eq) begin
        bad++; $display("FAIL rnd_id_valid: cycle %0d got %b want %b", c, id_valid, eq);
      end
      if (eq) begin
        total++;
        if (id_pc !== q[0].pc || id_instr !== q[0].instr || fetch_fault !== q[0].fault) begin
          bad++; $display("FAIL rnd_head: cycle %0d got %h/%h/%b want %h/%h/%b",
                          c, id_pc, id_instr, fetch_fault, q[0].pc, q[0].instr, q[0].fault);
        end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    clear_model();
    force_lat = 0;
    test_reset();
    test_stream();
    test_full();
    test_flush_inflight();
    test_flush_rsp();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
